// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between a fetch port and a data port. Data has priority, and a
// starvation counter bounds fetch waits. Define MEM_ARB_IBUF_EN to add a one-entry fetch buffer.
module mem_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int unsigned   TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [7:0]    StarveMax = 8'(STARVE_MAX);
    localparam logic [TW-1:0] TmoLast   = TW'(TIMEOUT - 1);
    localparam bit            TmoEn     = (TIMEOUT != 0);

    typedef enum logic [1:0] {StIdle, StIWait, StDWait} state_e;

    state_e        state_q, state_d;
    logic [7:0]    starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;
    logic          err_q, err_d;

    logic          d_grant;
    logic          ibuf_hit;
    logic [DW-1:0] ibuf_data;

    // Fetch only preempts data once it has watched STARVE_MAX data grants go by.
    assign d_grant = d_req && !(i_req && starve_q == StarveMax);

`ifdef MEM_ARB_IBUF_EN
    logic          buf_vld_q, buf_vld_d;
    logic [AW-1:0] buf_addr_q, buf_addr_d;
    logic [DW-1:0] buf_data_q, buf_data_d;

    assign ibuf_hit  = (state_q == StIdle) && i_req && buf_vld_q && (i_addr == buf_addr_q) &&
                       !d_grant;
    assign ibuf_data = buf_data_q;

    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        if (state_q == StIWait && mem_ack) begin
            buf_vld_d  = 1'b1;
            buf_addr_d = mem_addr_q;
            buf_data_d = mem_rdata;
        end
        if (state_q == StIdle && d_grant && d_we && d_addr == buf_addr_q) begin
            buf_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
        end
    end
`else
    assign ibuf_hit  = 1'b0;
    assign ibuf_data = '0;
`endif

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (d_grant) begin
                    state_d     = StDWait;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (i_req && starve_q != StarveMax) begin
                        starve_d = starve_q + 8'd1;
                    end
                end else if (ibuf_hit) begin
                    i_rdata_d = ibuf_data;
                    i_ready_d = 1'b1;
                    starve_d  = '0;
                end else if (i_req) begin
                    state_d     = StIWait;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            StIWait, StDWait: begin
                // An ack on the timeout cycle still counts as a normal completion.
                if (mem_ack) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    if (state_q == StIWait) begin
                        i_rdata_d = mem_rdata;
                        i_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = mem_we_q ? '0 : mem_rdata;
                        d_ready_d = 1'b1;
                    end
                end else if (TmoEn && tmo_q == TmoLast) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == StIWait) begin
                        i_rdata_d = '0;
                        i_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_ready_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (!i_req) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            err_q       <= err_d;
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, starvation, timeout, async reset.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(
        .AW        (32),
        .DW        (32),
        .STARVE_MAX(4),
        .TIMEOUT   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ready  (i_ready),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        // Reset state
        tick();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
        chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // 1) Fetch with ack in cycle 3
        i_req  = 1'b1;
        i_addr = 32'h10;
        tick();
        chk("f_req_c1", {31'd0, mem_req}, 32'd1);
        chk("f_we", {31'd0, mem_we}, 32'd0);
        chk("f_addr", mem_addr, 32'h10);
        tick();
        chk("f_req_c2", {31'd0, mem_req}, 32'd1);
        tick();
        chk("f_req_c3", {31'd0, mem_req}, 32'd1);
        chk("f_rdy_c3", {31'd0, i_ready}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2402000A;
        tick();
        chk("f_rdy_c4", {31'd0, i_ready}, 32'd1);
        chk("f_rdata", i_rdata, 32'h2402000A);
        chk("f_req_c4", {31'd0, mem_req}, 32'd0);
        chk("f_err", {31'd0, err}, 32'd0);
        mem_ack = 1'b0;
        i_req   = 1'b0;
        tick();
        chk("f_rdy_c5", {31'd0, i_ready}, 32'd0);
        chk("f_rdata_hold", i_rdata, 32'h2402000A);

        // 2) Simultaneous requests: data write first, then fetch
        i_req   = 1'b1;
        i_addr  = 32'h20;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'hDEADBEEF;
        tick();
        chk("p_req", {31'd0, mem_req}, 32'd1);
        chk("p_we", {31'd0, mem_we}, 32'd1);
        chk("p_addr", mem_addr, 32'h40);
        chk("p_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        chk("p_d_rdy", {31'd0, d_ready}, 32'd1);
        chk("p_d_rdata_wr", d_rdata, 32'd0);
        chk("p_req_off", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        tick();
        chk("p_i_req", {31'd0, mem_req}, 32'd1);
        chk("p_i_we", {31'd0, mem_we}, 32'd0);
        chk("p_i_addr", mem_addr, 32'h20);
        chk("p_d_rdy_off", {31'd0, d_ready}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h11112222;
        tick();
        chk("p_i_rdy", {31'd0, i_ready}, 32'd1);
        chk("p_i_rdata", i_rdata, 32'h11112222);
        mem_ack = 1'b0;
        i_req   = 1'b0;
        tick();

        // 3) Starvation: four data reads, then fetch, then data again
        i_req  = 1'b1;
        i_addr = 32'h200;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h100;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("s_d_addr", mem_addr, 32'h100);
            chk("s_d_req", {31'd0, mem_req}, 32'd1);
            mem_ack   = 1'b1;
            mem_rdata = 32'hA0 + 32'(n);
            tick();
            chk("s_d_rdy", {31'd0, d_ready}, 32'd1);
            chk("s_d_rdata", d_rdata, 32'hA0 + 32'(n));
            mem_ack = 1'b0;
        end
        tick();
        chk("s_i_addr", mem_addr, 32'h200);
        chk("s_i_we", {31'd0, mem_we}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
        tick();
        chk("s_i_rdy", {31'd0, i_ready}, 32'd1);
        chk("s_i_rdata", i_rdata, 32'h0BADF00D);
        mem_ack = 1'b0;
        i_req   = 1'b0;
        tick();
        chk("s_d_resume", mem_addr, 32'h100);
        chk("s_d_resume_req", {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hA4;
        tick();
        chk("s_d_rdy5", {31'd0, d_ready}, 32'd1);
        chk("s_d_rdata5", d_rdata, 32'hA4);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        tick();

        // 4) Timeout after 8 cycles of mem_req without ack
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h300;
        mem_rdata = 32'hFFFF0000;
        tick();
        for (int c = 1; c <= 8; c++) begin
            chk("t_req_hi", {31'd0, mem_req}, 32'd1);
            chk("t_rdy_lo", {31'd0, d_ready}, 32'd0);
            if (c == 1) d_req = 1'b0;
            tick();
        end
        chk("t_rdy", {31'd0, d_ready}, 32'd1);
        chk("t_err", {31'd0, err}, 32'd1);
        chk("t_rdata", d_rdata, 32'd0);
        chk("t_req_lo", {31'd0, mem_req}, 32'd0);
        tick();
        chk("t_err_pulse", {31'd0, err}, 32'd0);
        chk("t_rdy_pulse", {31'd0, d_ready}, 32'd0);

        // Ack on the timeout cycle wins
        d_req  = 1'b1;
        d_addr = 32'h340;
        tick();
        d_req = 1'b0;
        repeat (7) tick();
        chk("a_req_c8", {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555AAAA;
        tick();
        chk("a_rdy", {31'd0, d_ready}, 32'd1);
        chk("a_err", {31'd0, err}, 32'd0);
        chk("a_rdata", d_rdata, 32'h5555AAAA);
        mem_ack = 1'b0;
        tick();

        // 5) Async reset while waiting on a data write
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h400;
        d_wdata = 32'h01020304;
        tick();
        chk("r_req_before", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("r_req_async", {31'd0, mem_req}, 32'd0);
        chk("r_rdy_async", {31'd0, d_ready}, 32'd0);
        chk("r_err_async", {31'd0, err}, 32'd0);
        chk("r_addr_async", mem_addr, 32'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        tick();
        chk("r_rdy_in_rst", {31'd0, d_ready}, 32'd0);
        rst    = 1'b1;
        tick();
        i_req  = 1'b1;
        i_addr = 32'h10;
        tick();
        chk("r_f_req", {31'd0, mem_req}, 32'd1);
        chk("r_f_addr", mem_addr, 32'h10);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        chk("r_f_rdy", {31'd0, i_ready}, 32'd1);
        chk("r_f_rdata", i_rdata, 32'hCAFEF00D);
        chk("r_f_err", {31'd0, err}, 32'd0);
        chk("r_d_rdy", {31'd0, d_ready}, 32'd0);
        mem_ack = 1'b0;
        i_req   = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
